// File: rtl/reset_ctrl_fsm_if.sv
// Memory handshake bundle between the control FSM and the instruction/data memories.
//
// Signals:
//   imem_req  : instruction fetch request (controller -> memory)
//   imem_addr : fetch address, always the current PC (controller -> memory)
//   imem_ack  : fetch complete, imem_data valid in the same cycle (memory -> controller)
//   imem_data : 10-bit fetched instruction (memory -> controller)
//   dmem_req  : load request (controller -> memory)
//   dmem_ack  : load complete, data written back next cycle (memory -> controller)
//
// Modports:
//   master : controller side
//   slave  : memory side
`timescale 1ns/1ps

interface reset_ctrl_fsm_if #(
    parameter int PC_W = 8
) ();

    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ack;
    logic [9:0]      imem_data;
    logic            dmem_req;
    logic            dmem_ack;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_data,
        output dmem_req,
        input  dmem_ack
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_data,
        input  dmem_req,
        output dmem_ack
    );

endinterface

// File: rtl/reset_ctrl_fsm.sv
// Multi-cycle control FSM for a small 10-bit-instruction core.
// Sequence: INIT -> FETCH -> DECODE -> EXEC -> (WB) -> FETCH, with HALT as a
// terminal state left only through reset.
//
// Ports:
//   CLK       : clock, all state updates on the rising edge
//   RESET_N   : asynchronous active-low reset
//   bus       : memory handshake (reset_ctrl_fsm_if.master)
//   alu_zero  : ALU compare-equal flag, sampled in EXEC for beq
//   reg_init  : register-file constant-load strobe (INIT only)
//   instr_out : instruction latched at the end of FETCH
//   R1_CTRL   : read-port-A select
//   R2_CTRL   : read-port-B select
//   RegWrite  : register write enable (WB only)
//   writeReg  : destination register index
//   halted    : core stopped
`timescale 1ns/1ps

module reset_ctrl_fsm #(
    parameter int          PC_W     = 8,
    parameter int unsigned RESET_PC = 0
) (
    input  logic             CLK,
    input  logic             RESET_N,
    reset_ctrl_fsm_if.master bus,
    input  logic             alu_zero,
    output logic             reg_init,
    output logic [9:0]       instr_out,
    output logic [3:0]       R1_CTRL,
    output logic [3:0]       R2_CTRL,
    output logic             RegWrite,
    output logic [3:0]       writeReg,
    output logic             halted
);

    typedef enum logic [2:0] {
        INIT   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_t;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SHIFT = 3'b001;
    localparam logic [2:0] OP_JOIN  = 3'b010;
    localparam logic [2:0] OP_AND   = 3'b011;
    localparam logic [2:0] OP_BEQ   = 3'b100;
    localparam logic [2:0] OP_LOAD  = 3'b101;
    localparam logic [2:0] OP_NOP   = 3'b110;
    localparam logic [2:0] OP_HALT  = 3'b111;

    state_t          state;
    state_t          state_next;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_next;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] branch_offset;
    logic [9:0]      instr_next;
    logic [3:0]      r1_next;
    logic [3:0]      r2_next;
    logic [3:0]      wr_next;
    logic [2:0]      opcode;
    logic [2:0]      fetch_opcode;
    logic            reg_init_raw;

    assign opcode        = instr_out[9:7];
    assign fetch_opcode  = bus.imem_data[9:7];
    assign pc_inc        = pc + PC_W'(1);
    // Size cast of a signed operand sign-extends the 7-bit branch offset.
    assign branch_offset = PC_W'($signed(instr_out[6:0]));
    assign bus.imem_addr = pc;

    // The reset state is INIT, but the strobe must stay low while reset is
    // held; gating with RESET_N makes it high only in the real INIT cycle.
    assign reg_init = reg_init_raw & RESET_N;

    // State and datapath registers; reset forces INIT and clears everything
    // immediately so any pending request drops in the same cycle.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= INIT;
            pc        <= PC_W'(RESET_PC);
            instr_out <= '0;
            R1_CTRL   <= '0;
            R2_CTRL   <= '0;
            writeReg  <= '0;
        end else begin
            state     <= state_next;
            pc        <= pc_next;
            instr_out <= instr_next;
            R1_CTRL   <= r1_next;
            R2_CTRL   <= r2_next;
            writeReg  <= wr_next;
        end
    end

    // Next-state, next-PC and output decode. Latched instruction fields only
    // change on the FETCH->DECODE transition so they stay stable through WB.
    always_comb begin
        state_next   = state;
        pc_next      = pc;
        instr_next   = instr_out;
        r1_next      = R1_CTRL;
        r2_next      = R2_CTRL;
        wr_next      = writeReg;
        reg_init_raw = 1'b0;
        bus.imem_req = 1'b0;
        bus.dmem_req = 1'b0;
        RegWrite     = 1'b0;
        halted       = 1'b0;

        case (state)
            INIT: begin
                reg_init_raw = 1'b1;
                state_next   = FETCH;
            end

            FETCH: begin
                bus.imem_req = 1'b1;
                if (bus.imem_ack) begin
                    instr_next = bus.imem_data;
                    r1_next    = 4'd0;
                    r2_next    = 4'd0;
                    wr_next    = 4'd0;
                    case (fetch_opcode)
                        OP_ADD, OP_SHIFT, OP_JOIN: begin
                            wr_next = bus.imem_data[6:3];
                        end
                        OP_AND: begin
                            r1_next = 4'd1;
                            wr_next = {1'b0, bus.imem_data[5:3]};
                        end
                        OP_BEQ: begin
                            r1_next = 4'd3;
                            r2_next = 4'd1;
                        end
                        OP_LOAD: begin
                            r1_next = 4'd4;
                            r2_next = 4'd1;
                            wr_next = 4'd14;
                        end
                        default: begin
                        end
                    endcase
                    state_next = DECODE;
                end
            end

            DECODE: begin
                state_next = (opcode == OP_HALT) ? HALT : EXEC;
            end

            EXEC: begin
                case (opcode)
                    OP_ADD, OP_SHIFT, OP_JOIN, OP_AND: begin
                        state_next = WB;
                    end
                    OP_LOAD: begin
                        bus.dmem_req = 1'b1;
                        if (bus.dmem_ack) begin
                            state_next = WB;
                        end
                    end
                    OP_BEQ: begin
                        pc_next    = alu_zero ? (pc_inc + branch_offset) : pc_inc;
                        state_next = FETCH;
                    end
                    OP_NOP: begin
                        pc_next    = pc_inc;
                        state_next = FETCH;
                    end
                    default: begin
                        state_next = HALT;
                    end
                endcase
            end

            WB: begin
                RegWrite   = 1'b1;
                pc_next    = pc_inc;
                state_next = FETCH;
            end

            HALT: begin
                halted = 1'b1;
            end

            default: begin
                state_next = INIT;
            end
        endcase
    end

endmodule
